// File: rtl/pl_pkg.sv
// Shared encodings and constants for the pipelined CPU front end.
package pl_pkg;

    localparam logic [1:0]  PCSRC_PC4    = 2'b00;
    localparam logic [1:0]  PCSRC_BPC    = 2'b01;
    localparam logic [1:0]  PCSRC_RPC    = 2'b10;
    localparam logic [1:0]  PCSRC_JPC    = 2'b11;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pl_inst_mem.sv
// Instruction ROM: 64 words addressed by a[7:2], so the image repeats every 256 bytes.
module pl_inst_mem
    import pl_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] inst
);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{a[31:8], a[1:0]};

    // NOTE: inst gets a default before the case so the block can never infer a latch.
    always_comb begin
        inst = NOP;
        case (a[7:2])
            6'h00: inst = 32'h3c010000;
            6'h01: inst = 32'h34240050;
            6'h02: inst = 32'h0c00001b;
            6'h03: inst = 32'h20050004;
            6'h04: inst = 32'hac820000;
            6'h05: inst = 32'h8c890000;
            6'h06: inst = 32'h01244022;
            6'h07: inst = 32'h20050003;
            6'h08: inst = 32'h20a5ffff;
            6'h09: inst = 32'h34a8ffff;
            6'h0a: inst = 32'h39085555;
            6'h0b: inst = 32'h2009ffff;
            6'h0c: inst = 32'h312affff;
            6'h0d: inst = 32'h01493025;
            6'h0e: inst = 32'h01494026;
            6'h0f: inst = 32'h01463824;
            6'h10: inst = 32'h10a00003;
            6'h11: inst = 32'h00000000;
            6'h12: inst = 32'h08000008;
            6'h13: inst = 32'h00000000;
            6'h14: inst = 32'h2005ffff;
            6'h15: inst = 32'h000543c0;
            6'h16: inst = 32'h00084400;
            6'h17: inst = 32'h00084403;
            6'h18: inst = 32'h000843c2;
            6'h19: inst = 32'h08000019;
            6'h1a: inst = 32'h00000000;
            6'h1b: inst = 32'h00004020;
            6'h1c: inst = 32'h8c890000;
            6'h1d: inst = 32'h01094020;
            6'h1e: inst = 32'h20a5ffff;
            6'h1f: inst = 32'h14a0fffc;
            6'h20: inst = 32'h20840004;
            6'h21: inst = 32'h03e00008;
            6'h22: inst = 32'h00081000;
            default: inst = NOP;
        endcase
    end

endmodule

// File: rtl/pl_if_stage.sv
// Instruction fetch stage: PC register, next-PC select, ROM lookup and the IF/ID pipeline register.
module pl_if_stage
    import pl_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        wpcir,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        cancel,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] ifcnt
);

    logic [31:0] target;
    logic [31:0] npc;

    assign pc4 = pc + 32'd4;

    always_comb begin
        target = pc4;
        case (pcsrc)
            PCSRC_PC4: target = pc4;
            PCSRC_BPC: target = bpc;
            PCSRC_RPC: target = rpc;
            PCSRC_JPC: target = jpc;
            default:   target = pc4;
        endcase
    end

    // Fetch addresses are always word aligned, whatever the jump source supplied.
    assign npc = {target[31:2], 2'b00};

    pl_inst_mem u_inst_mem (
        .a    (pc),
        .inst (inst)
    );

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc <= RESET_VECTOR;
        end else if (wpcir) begin
            pc <= npc;
        end
    end

    // A cancel squashes the slot even during a stall; only a delivered instruction is counted.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dpc4   <= '0;
            dinst  <= NOP;
            dvalid <= 1'b0;
            ifcnt  <= '0;
        end else if (cancel) begin
            dinst  <= NOP;
            dvalid <= 1'b0;
            if (wpcir) begin
                dpc4 <= pc4;
            end
        end else if (wpcir) begin
            dinst  <= inst;
            dpc4   <= pc4;
            dvalid <= 1'b1;
            ifcnt  <= ifcnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pl_if_stage.sv
// Self-checking bench for pl_if_stage: directed scenarios plus randomized traffic against a reference model.
module tb_pl_if_stage;

    logic        clk;
    logic        clrn;
    logic        wpcir;
    logic [1:0]  pcsrc;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        cancel;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic [31:0] ifcnt;

    int checks;
    int errors;

    // Reference program image, word 0 at byte address 0.
    localparam logic [31:0] ROM_IMG [0:34] = '{
        32'h3c010000, 32'h34240050, 32'h0c00001b, 32'h20050004,
        32'hac820000, 32'h8c890000, 32'h01244022, 32'h20050003,
        32'h20a5ffff, 32'h34a8ffff, 32'h39085555, 32'h2009ffff,
        32'h312affff, 32'h01493025, 32'h01494026, 32'h01463824,
        32'h10a00003, 32'h00000000, 32'h08000008, 32'h00000000,
        32'h2005ffff, 32'h000543c0, 32'h00084400, 32'h00084403,
        32'h000843c2, 32'h08000019, 32'h00000000, 32'h00004020,
        32'h8c890000, 32'h01094020, 32'h20a5ffff, 32'h14a0fffc,
        32'h20840004, 32'h03e00008, 32'h00081000
    };

    logic [31:0] m_pc;
    logic [31:0] m_dpc4;
    logic [31:0] m_dinst;
    logic        m_dvalid;
    logic [31:0] m_ifcnt;

    pl_if_stage dut (
        .clk    (clk),
        .clrn   (clrn),
        .wpcir  (wpcir),
        .pcsrc  (pcsrc),
        .bpc    (bpc),
        .rpc    (rpc),
        .jpc    (jpc),
        .cancel (cancel),
        .pc     (pc),
        .pc4    (pc4),
        .inst   (inst),
        .dpc4   (dpc4),
        .dinst  (dinst),
        .dvalid (dvalid),
        .ifcnt  (ifcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        int idx;
        idx = int'((addr % 256) / 4);
        return (idx < 35) ? ROM_IMG[idx] : 32'h0;
    endfunction

    function automatic void model_reset();
        m_pc     = 32'h0;
        m_dpc4   = 32'h0;
        m_dinst  = 32'h0;
        m_dvalid = 1'b0;
        m_ifcnt  = 32'h0;
    endfunction

    function automatic void model_edge(input logic w, input logic [1:0] s, input logic [31:0] b,
                                       input logic [31:0] r, input logic [31:0] j, input logic c);
        logic [31:0] seq;
        logic [31:0] dest;
        seq = m_pc + 32'd4;
        if (s == 2'd0)      dest = seq;
        else if (s == 2'd1) dest = b;
        else if (s == 2'd2) dest = r;
        else                dest = j;
        dest = dest - (dest % 4);
        if (c) begin
            m_dinst  = 32'h0;
            m_dvalid = 1'b0;
            if (w) m_dpc4 = seq;
        end else if (w) begin
            m_dinst  = rom_word(m_pc);
            m_dpc4   = seq;
            m_dvalid = 1'b1;
            m_ifcnt  = m_ifcnt + 32'd1;
        end
        if (w) m_pc = dest;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".pc"},     pc,             m_pc);
        check({tag, ".dpc4"},   dpc4,           m_dpc4);
        check({tag, ".dinst"},  dinst,          m_dinst);
        check({tag, ".dvalid"}, {31'b0, dvalid}, {31'b0, m_dvalid});
        check({tag, ".ifcnt"},  ifcnt,          m_ifcnt);
    endtask

    // One clock: drive after the falling edge, check fetch outputs, then registers just after the rising edge.
    task automatic cycle(input string tag, input logic w, input logic [1:0] s, input logic [31:0] b,
                         input logic [31:0] r, input logic [31:0] j, input logic c);
        @(negedge clk);
        wpcir = w; pcsrc = s; bpc = b; rpc = r; jpc = j; cancel = c;
        #1;
        check({tag, ".pc4"},  pc4,  m_pc + 32'd4);
        check({tag, ".inst"}, inst, rom_word(m_pc));
        @(posedge clk);
        model_edge(w, s, b, r, j, c);
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] held_cnt;
        checks = 0;
        errors = 0;
        clrn = 1'b0; wpcir = 1'b0; pcsrc = 2'b00; bpc = '0; rpc = '0; jpc = '0; cancel = 1'b0;
        model_reset();

        #12;
        check_regs("reset");
        @(negedge clk);
        clrn = 1'b1;

        // First fetch after reset release.
        #1;
        check("boot.inst", inst, 32'h3c010000);
        cycle("boot", 1'b1, 2'b00, '0, '0, '0, 1'b0);
        check("boot.pc_abs", pc, 32'h04);
        check("boot.dinst_abs", dinst, 32'h3c010000);
        check("boot.dpc4_abs", dpc4, 32'h04);
        check("boot.dvalid_abs", {31'b0, dvalid}, 32'h1);
        check("boot.ifcnt_abs", ifcnt, 32'h1);

        // Jump taken at pc=0x08: the jal itself lands in IF/ID on the same edge.
        cycle("seq", 1'b1, 2'b00, '0, '0, '0, 1'b0);
        cycle("jal", 1'b1, 2'b11, 32'h1234, 32'h5678, 32'h6c, 1'b0);
        check("jal.pc_abs", pc, 32'h6c);
        check("jal.dinst_abs", dinst, 32'h0c00001b);
        #1;
        check("jal.inst_abs", inst, 32'h00004020);

        // Two-cycle stall at 0x70 with garbage on pcsrc.
        cycle("to70", 1'b1, 2'b00, '0, '0, '0, 1'b0);
        held_cnt = ifcnt;
        cycle("stall0", 1'b0, 2'b11, 32'h40, 32'h44, 32'h48, 1'b0);
        cycle("stall1", 1'b0, 2'b01, 32'h40, 32'h44, 32'h48, 1'b0);
        check("stall.pc_abs", pc, 32'h70);
        check("stall.ifcnt_abs", ifcnt, held_cnt);
        cycle("resume", 1'b1, 2'b00, '0, '0, '0, 1'b0);
        check("resume.pc_abs", pc, 32'h74);

        // Cancel with and without advance.
        held_cnt = ifcnt;
        cycle("cancel_w1", 1'b1, 2'b00, '0, '0, '0, 1'b1);
        check("cancel_w1.dinst_abs", dinst, 32'h0);
        check("cancel_w1.ifcnt_abs", ifcnt, held_cnt);
        cycle("cancel_w0", 1'b0, 2'b10, '0, 32'h20, '0, 1'b1);
        check("cancel_w0.pc_abs", pc, 32'h78);

        // Misaligned register target, ROM aliasing and pc4 wrap.
        cycle("jr", 1'b1, 2'b10, '0, 32'h0000006f, '0, 1'b0);
        check("jr.pc_abs", pc, 32'h6c);
        cycle("alias", 1'b1, 2'b11, '0, '0, 32'h100, 1'b0);
        #1;
        check("alias.inst_abs", inst, 32'h3c010000);
        cycle("wrap", 1'b1, 2'b11, '0, '0, 32'hfffffffc, 1'b0);
        #1;
        check("wrap.pc4_abs", pc4, 32'h0);
        cycle("wrapped", 1'b1, 2'b00, '0, '0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic        c;
            logic [1:0]  s;
            logic [31:0] b, r, j;
            w = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 5) == 0);
            s = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
            r = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
            j = ($urandom_range(0, 7) == 0) ? 32'hfffffffc : 32'($urandom_range(0, 511));
            cycle("rand", w, s, b, r, j, c);
        end

        // Asynchronous reset while stalled and cancelling.
        @(negedge clk);
        wpcir = 1'b0; cancel = 1'b1;
        #1;
        clrn = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        @(negedge clk);
        cancel = 1'b0;
        clrn = 1'b1;
        #1;
        check("rst_release.inst_abs", inst, 32'h3c010000);
        cycle("post_rst", 1'b1, 2'b00, '0, '0, '0, 1'b0);
        check("post_rst.dinst_abs", dinst, 32'h3c010000);
        check("post_rst.ifcnt_abs", ifcnt, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
